// File: rtl/rfphoenix_memreq_queue.sv
// Memory request queue between execute stage and BIU: in-order issue, outstanding-limit,
// ROB-entry flush by kill bits, and a one-cycle registered response path back to the core.
module rfphoenix_memreq_queue #(
    parameter int DEPTH   = 8,
    parameter int AW      = 32,
    parameter int DW      = 512,
    parameter int MAX_OUT = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_wr,
    input  logic [3:0]    req_rid,
    input  logic [3:0]    req_step,
    input  logic [3:0]    req_func,
    input  logic [3:0]    req_sz,
    input  logic [AW-1:0] req_adr,
    input  logic [DW-1:0] req_dat,
    output logic          req_full,
    output logic          req_ovf,
    input  logic          flush_i,
    input  logic [3:0]    flush_rid,
    output logic          biu_v,
    input  logic          biu_rdy,
    output logic [3:0]    biu_rid,
    output logic [3:0]    biu_step,
    output logic [3:0]    biu_func,
    output logic [3:0]    biu_sz,
    output logic [AW-1:0] biu_adr,
    output logic [DW-1:0] biu_dat,
    input  logic          rsp_v,
    input  logic [3:0]    rsp_rid,
    input  logic [3:0]    rsp_step,
    input  logic [DW-1:0] rsp_res,
    output logic          mresp_v,
    output logic [3:0]    mresp_rid,
    output logic [3:0]    mresp_step,
    output logic [DW-1:0] mresp_res,
    output logic [3:0]    outstanding
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [3:0]    rid;
        logic [3:0]    step;
        logic [3:0]    func;
        logic [3:0]    sz;
        logic [AW-1:0] adr;
        logic [DW-1:0] dat;
    } entry_t;

    entry_t           mem [DEPTH];
    entry_t           head;
    logic [DEPTH-1:0] kill, kill_nxt, live;
    logic [PW-1:0]    rptr, wptr;
    logic [CW-1:0]    count, count_nxt;
    logic             push, pop, handshake, head_kill;

    assign head      = mem[rptr];
    assign head_kill = (count != '0) & kill[rptr];
    assign biu_v     = (count != '0) & ~kill[rptr] & (outstanding < 4'(MAX_OUT));
    assign handshake = biu_v & biu_rdy;
    assign pop       = handshake | head_kill;
    // Full is the registered flag, so a same-cycle pop never frees room for a push.
    assign push      = req_wr & ~req_full;

    assign biu_rid  = head.rid;
    assign biu_step = head.step;
    assign biu_func = head.func;
    assign biu_sz   = head.sz;
    assign biu_adr  = head.adr;
    assign biu_dat  = head.dat;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase
    end

    // An entry is live when its distance from the read pointer is below the occupancy.
    always_comb begin
        live     = '0;
        kill_nxt = kill;
        for (int i = 0; i < DEPTH; i++) begin
            live[i] = ({1'b0, PW'(i) - rptr} < count);
            if (flush_i && live[i] && mem[i].rid == flush_rid)
                kill_nxt[i] = 1'b1;
        end
        if (push)
            kill_nxt[wptr] = flush_i & (req_rid == flush_rid);
    end

    // NOTE: storage is reset too, so the head fields read 0 out of reset without gating them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else if (push) begin
            mem[wptr] <= '{rid: req_rid, step: req_step, func: req_func, sz: req_sz,
                           adr: req_adr, dat: req_dat};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rptr        <= '0;
            wptr        <= '0;
            count       <= '0;
            kill        <= '0;
            req_full    <= 1'b0;
            req_ovf     <= 1'b0;
            outstanding <= '0;
        end else begin
            if (push) wptr <= wptr + PW'(1);
            if (pop)  rptr <= rptr + PW'(1);
            count    <= count_nxt;
            kill     <= kill_nxt;
            req_full <= (count_nxt == CW'(DEPTH));
            if (req_wr && req_full)
                req_ovf <= 1'b1;
            case ({handshake, rsp_v})
                2'b10:   outstanding <= outstanding + 4'd1;
                2'b01:   if (outstanding != '0) outstanding <= outstanding - 4'd1;
                default: outstanding <= outstanding;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mresp_v    <= 1'b0;
            mresp_rid  <= '0;
            mresp_step <= '0;
            mresp_res  <= '0;
        end else begin
            mresp_v <= rsp_v;
            if (rsp_v) begin
                mresp_rid  <= rsp_rid;
                mresp_step <= rsp_step;
                mresp_res  <= rsp_res;
            end
        end
    end

endmodule

// File: tb/tb_rfphoenix_memreq_queue.sv
// Bench for rfphoenix_memreq_queue: queue-based reference model and scoreboards checked by a
// negedge monitor, with directed scenarios followed by a randomized run.
module tb_rfphoenix_memreq_queue;

    localparam int DEPTH   = 8;
    localparam int AW      = 32;
    localparam int DW      = 512;
    localparam int MAX_OUT = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_wr;
    logic [3:0]    req_rid, req_step, req_func, req_sz;
    logic [AW-1:0] req_adr;
    logic [DW-1:0] req_dat;
    logic          req_full, req_ovf;
    logic          flush_i;
    logic [3:0]    flush_rid;
    logic          biu_v, biu_rdy;
    logic [3:0]    biu_rid, biu_step, biu_func, biu_sz;
    logic [AW-1:0] biu_adr;
    logic [DW-1:0] biu_dat;
    logic          rsp_v;
    logic [3:0]    rsp_rid, rsp_step;
    logic [DW-1:0] rsp_res;
    logic          mresp_v;
    logic [3:0]    mresp_rid, mresp_step;
    logic [DW-1:0] mresp_res;
    logic [3:0]    outstanding;

    rfphoenix_memreq_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .MAX_OUT(MAX_OUT)) dut (
        .clk(clk), .rst(rst),
        .req_wr(req_wr), .req_rid(req_rid), .req_step(req_step), .req_func(req_func),
        .req_sz(req_sz), .req_adr(req_adr), .req_dat(req_dat),
        .req_full(req_full), .req_ovf(req_ovf),
        .flush_i(flush_i), .flush_rid(flush_rid),
        .biu_v(biu_v), .biu_rdy(biu_rdy),
        .biu_rid(biu_rid), .biu_step(biu_step), .biu_func(biu_func), .biu_sz(biu_sz),
        .biu_adr(biu_adr), .biu_dat(biu_dat),
        .rsp_v(rsp_v), .rsp_rid(rsp_rid), .rsp_step(rsp_step), .rsp_res(rsp_res),
        .mresp_v(mresp_v), .mresp_rid(mresp_rid), .mresp_step(mresp_step), .mresp_res(mresp_res),
        .outstanding(outstanding)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]    rid, step, func, sz;
        logic [AW-1:0] adr;
        logic [DW-1:0] dat;
        bit            kill;
    } mreq_t;

    typedef struct {
        int            cyc;
        logic [3:0]    rid, step;
        logic [DW-1:0] res;
    } mrsp_t;

    mreq_t mq[$];     // requests the queue holds, in push order
    mrsp_t rq[$];     // responses issued, awaiting forwarding
    int    m_out  = 0;
    bit    m_full = 0;
    bit    m_ovf  = 0;
    int    cyc    = 0;
    int    hs_cnt = 0;
    int    n_cmp  = 0;
    int    n_bad  = 0;

    task automatic check(input string name, input logic [639:0] act, input logic [639:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand_dat();
        logic [DW-1:0] r;
        for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    // Reference model: one step per clock edge, from the queue's documented rules.
    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            mq.delete();
            rq.delete();
            m_out  = 0;
            m_full = 0;
            m_ovf  = 0;
        end else begin
            bit    hk, ev, hs;
            mreq_t e;
            cyc++;
            hk = (mq.size() > 0) && mq[0].kill;
            ev = (mq.size() > 0) && !mq[0].kill && (m_out < MAX_OUT);
            hs = ev && biu_rdy;
            if (hs || hk) void'(mq.pop_front());
            if (flush_i)
                foreach (mq[i]) if (mq[i].rid == flush_rid) mq[i].kill = 1;
            if (req_wr) begin
                if (m_full) m_ovf = 1;
                else begin
                    e.rid = req_rid; e.step = req_step; e.func = req_func; e.sz = req_sz;
                    e.adr = req_adr; e.dat = req_dat;
                    e.kill = flush_i && (req_rid == flush_rid);
                    mq.push_back(e);
                end
            end
            m_full = (mq.size() == DEPTH);
            if (hs && !rsp_v) m_out++;
            else if (!hs && rsp_v && m_out > 0) m_out--;
        end
    end

    // Monitor: compares DUT outputs mid-cycle against the model and response scoreboard.
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            bit ev, emv;
            ev = (mq.size() > 0) && !mq[0].kill && (m_out < MAX_OUT);
            check("biu_v", 640'(biu_v), 640'(ev));
            if (ev)
                check("biu_req", 640'({biu_rid, biu_step, biu_func, biu_sz, biu_adr, biu_dat}),
                      640'({mq[0].rid, mq[0].step, mq[0].func, mq[0].sz, mq[0].adr, mq[0].dat}));
            check("req_full", 640'(req_full), 640'(m_full));
            check("req_ovf", 640'(req_ovf), 640'(m_ovf));
            check("outstanding", 640'(outstanding), 640'(m_out));
            if (biu_v && biu_rdy) hs_cnt++;
            emv = (rq.size() > 0) && (rq[0].cyc == cyc - 1);
            check("mresp_v", 640'(mresp_v), 640'(emv));
            if (emv) begin
                check("mresp", 640'({mresp_rid, mresp_step, mresp_res}),
                      640'({rq[0].rid, rq[0].step, rq[0].res}));
                void'(rq.pop_front());
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic cyc_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req_wr = 0; req_rid = 0; req_step = 0; req_func = 0; req_sz = 0; req_adr = 0; req_dat = 0;
        flush_i = 0; flush_rid = 0; rsp_v = 0; rsp_rid = 0; rsp_step = 0; rsp_res = 0;
    endtask

    task automatic do_reset();
        rst = 1; idle(); biu_rdy = 0;
        cyc_step(); cyc_step();
        rst = 0;
    endtask

    task automatic push_req(input logic [3:0] rid, input logic [AW-1:0] adr);
        req_wr = 1; req_rid = rid; req_step = 4'($urandom_range(0, 15));
        req_func = 4'($urandom_range(0, 2)); req_sz = 4'($urandom_range(0, 3));
        req_adr = adr; req_dat = rand_dat();
        cyc_step();
        req_wr = 0;
    endtask

    task automatic send_rsp(input logic [3:0] rid, input logic [3:0] step, input logic [DW-1:0] res);
        mrsp_t r;
        rsp_v = 1; rsp_rid = rid; rsp_step = step; rsp_res = res;
        r.cyc = cyc; r.rid = rid; r.step = step; r.res = res;
        rq.push_back(r);
        cyc_step();
        rsp_v = 0;
    endtask

    initial begin
        int h0;
        rst = 1; idle(); biu_rdy = 0;
        cyc_step(); cyc_step();
        check("rst_ctl", 640'({biu_v, req_full, req_ovf, mresp_v, outstanding}), 640'(0));
        check("rst_biu", 640'({biu_rid, biu_step, biu_func, biu_sz, biu_adr, biu_dat}), 640'(0));
        check("rst_mresp", 640'({mresp_rid, mresp_step, mresp_res}), 640'(0));
        rst = 0;

        // Three back-to-back pushes drain straight through
        biu_rdy = 1; h0 = hs_cnt;
        push_req(4'd1, 32'h100); push_req(4'd2, 32'h104); push_req(4'd3, 32'h108);
        cyc_step(); cyc_step();
        check("t1_handshakes", 640'(hs_cnt - h0), 640'(3));
        check("t1_outstanding", 640'(outstanding), 640'(3));

        // Fill to DEPTH, overflow, then drain exactly DEPTH entries
        do_reset();
        for (int i = 0; i < DEPTH + 1; i++) begin
            push_req(4'(i), 32'(i * 4));
            if (i == DEPTH - 1) check("t2_full", 640'(req_full), 640'(1));
        end
        check("t2_ovf", 640'(req_ovf), 640'(1));
        biu_rdy = 1; h0 = hs_cnt;
        for (int i = 0; i < 12; i++) send_rsp(4'(i), 4'd0, rand_dat());
        check("t2_drained", 640'(hs_cnt - h0), 640'(DEPTH));
        check("t2_empty", 640'(biu_v), 640'(0));

        // Outstanding limit blocks issue until a response returns
        do_reset();
        biu_rdy = 1; h0 = hs_cnt;
        for (int i = 0; i < 6; i++) push_req(4'(i), 32'h200 + 32'(i * 4));
        repeat (4) cyc_step();
        check("t3_limit_hs", 640'(hs_cnt - h0), 640'(MAX_OUT));
        check("t3_limit_v", 640'(biu_v), 640'(0));
        send_rsp(4'd0, 4'd0, rand_dat());
        repeat (3) cyc_step();
        check("t3_one_more", 640'(hs_cnt - h0), 640'(MAX_OUT + 1));
        check("t3_out", 640'(outstanding), 640'(MAX_OUT));

        // Flush removes every queued request of one ROB entry
        do_reset();
        push_req(4'd5, 32'h300); push_req(4'd6, 32'h304);
        push_req(4'd5, 32'h308); push_req(4'd7, 32'h30c);
        flush_i = 1; flush_rid = 4'd5; cyc_step(); flush_i = 0;
        biu_rdy = 1; h0 = hs_cnt;
        repeat (4) cyc_step();
        check("t4_survivors", 640'(hs_cnt - h0), 640'(2));
        check("t4_empty", 640'(biu_v), 640'(0));

        // Response register: one-cycle pulse with held fields
        send_rsp(4'd9, 4'd3, 512'hDEADBEEF);
        check("t5_mresp", 640'({mresp_v, mresp_rid, mresp_step, mresp_res}),
              640'({1'b1, 4'd9, 4'd3, 512'hDEADBEEF}));
        cyc_step();
        check("t5_pulse", 640'(mresp_v), 640'(0));

        // Handshake and response together leave outstanding unchanged
        do_reset(); h0 = hs_cnt;
        push_req(4'd1, 32'h400); push_req(4'd2, 32'h404); push_req(4'd3, 32'h408);
        biu_rdy = 1; cyc_step(); cyc_step();
        check("t6_out_before", 640'(outstanding), 640'(2));
        send_rsp(4'd1, 4'd0, rand_dat());
        check("t6_out_after", 640'(outstanding), 640'(2));
        check("t6_hs", 640'(hs_cnt - h0), 640'(3));

        // Reset mid-drain clears everything at once
        biu_rdy = 0;
        for (int i = 0; i < 4; i++) push_req(4'(10 + i), 32'h500 + 32'(i * 4));
        biu_rdy = 1; cyc_step();
        #2 rst = 1;
        #1;
        check("t7_rst_ctl", 640'({biu_v, req_full, req_ovf, mresp_v, outstanding}), 640'(0));
        check("t7_rst_biu", 640'({biu_rid, biu_step, biu_func, biu_sz, biu_adr, biu_dat}), 640'(0));
        cyc_step(); rst = 0; h0 = hs_cnt;
        repeat (5) cyc_step();
        check("t7_no_stale", 640'(hs_cnt - h0), 640'(0));

        // Randomized traffic against the model
        do_reset();
        for (int n = 0; n < 600; n++) begin
            req_wr = 1'($urandom_range(0, 1));
            req_rid = 4'($urandom_range(0, 7)); req_step = 4'($urandom_range(0, 15));
            req_func = 4'($urandom_range(0, 2)); req_sz = 4'($urandom_range(0, 3));
            req_adr = $urandom(); req_dat = rand_dat();
            flush_i = ($urandom_range(0, 7) == 0); flush_rid = 4'($urandom_range(0, 7));
            biu_rdy = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) == 0) begin
                mrsp_t r;
                rsp_v = 1; rsp_rid = 4'($urandom_range(0, 15)); rsp_step = 4'($urandom_range(0, 15));
                rsp_res = rand_dat();
                r.cyc = cyc; r.rid = rsp_rid; r.step = rsp_step; r.res = rsp_res;
                rq.push_back(r);
            end else rsp_v = 0;
            cyc_step();
        end
        idle();
        for (int n = 0; n < 300 && (mq.size() != 0 || m_out != 0); n++) begin
            biu_rdy = 1;
            if (m_out > 0) send_rsp(4'd0, 4'd0, rand_dat());
            else cyc_step();
        end
        cyc_step(); cyc_step();
        check("final_out", 640'(outstanding), 640'(0));
        check("final_biu_v", 640'(biu_v), 640'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
